// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
// Shared types for the operation-select path.
//   opr_mode_t      : operation mode consumed by select_action's SELECTOR input
//   BTN_C .. BTN_R  : bit positions of each button inside the 5-bit btn_db bus
// -----------------------------------------------------------------------------
package types_pkg;

    typedef enum logic [2:0] {
        RESET        = 3'd0,
        ADD          = 3'd1,
        SUB          = 3'd2,
        MUL          = 3'd3,
        LEADING_ONES = 3'd4,
        COUNT_ONES   = 3'd5
    } opr_mode_t;

    // btn_db bit order is {C,U,D,L,R}, MSB = C.
    localparam int BTN_C = 4;
    localparam int BTN_U = 3;
    localparam int BTN_D = 2;
    localparam int BTN_L = 1;
    localparam int BTN_R = 0;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronizes one raw, asynchronous push-button and debounces it.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous, active-high reset
//   raw   in   raw button level (asynchronous to clk)
//   level out  debounced level
// The debounced level flips only after the synchronized level has differed
// from it on DEBOUNCE_CYCLES consecutive edges; any agreeing edge clears the
// run, so short glitches are rejected.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (essential in the chain).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_mode_select.sv
// -----------------------------------------------------------------------------
// btn_mode_select
// Turns five board push-buttons into a latched operation mode.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   btnc..btnr in   raw buttons (centre, up, down, left, right), active-high
//   selector   out  latched opr_mode_t; holds between presses
//   mode_valid out  one-cycle pulse in the cycle selector took a press value
//   btn_db     out  debounced levels {C,U,D,L,R}
// A press is a rising edge of a debounced level. Simultaneous presses resolve
// with priority C > U > D > L > R. Releases never change selector.
// -----------------------------------------------------------------------------
module btn_mode_select
    import types_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnc,
    input  logic       btnu,
    input  logic       btnd,
    input  logic       btnl,
    input  logic       btnr,
    output opr_mode_t  selector,
    output logic       mode_valid,
    output logic [4:0] btn_db
);

    logic [4:0] raw;
    logic [4:0] db_prev;
    logic [4:0] press;
    logic       press_any;
    opr_mode_t  next_mode;

    assign raw = {btnc, btnu, btnd, btnl, btnr};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_btn_debounce (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[i]),
            .level (btn_db[i])
        );
    end

    // Only 0->1 transitions of a debounced level count as presses.
    assign press     = btn_db & ~db_prev;
    assign press_any = |press;

    // NOTE: next_mode gets a default before the if-chain so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_mode = RESET;
        if      (press[BTN_C]) next_mode = MUL;
        else if (press[BTN_U]) next_mode = LEADING_ONES;
        else if (press[BTN_D]) next_mode = COUNT_ONES;
        else if (press[BTN_L]) next_mode = ADD;
        else if (press[BTN_R]) next_mode = SUB;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_prev    <= '0;
            selector   <= RESET;
            mode_valid <= 1'b0;
        end else begin
            db_prev    <= btn_db;
            mode_valid <= press_any;
            if (press_any) begin
                selector <= next_mode;
            end
        end
    end

endmodule

// File: tb/tb_btn_mode_select.sv
// -----------------------------------------------------------------------------
// tb_btn_mode_select
// Directed bench for btn_mode_select with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
// "Edge 0" is the edge after which an input is changed; a raw level held from
// edge 0 reaches btn_db after edge 6 and selector/mode_valid after edge 7.
// -----------------------------------------------------------------------------
module tb_btn_mode_select;
    import types_pkg::*;

    logic       clk;
    logic       rst;
    logic       btnc, btnu, btnd, btnl, btnr;
    opr_mode_t  selector;
    logic       mode_valid;
    logic [4:0] btn_db;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    btn_mode_select #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btnc       (btnc),
        .btnu       (btnu),
        .btnd       (btnd),
        .btnl       (btnl),
        .btnr       (btnr),
        .selector   (selector),
        .mode_valid (mode_valid),
        .btn_db     (btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode_valid is a registered one-cycle pulse, so one negedge sample per pulse.
    always @(negedge clk) if (mode_valid === 1'b1) pulses++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        {btnc, btnu, btnd, btnl, btnr} = 5'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (selector !== RESET) begin
            errors++;
            $display("FAIL reset_selector got=%0d want=%0d", selector, RESET);
        end
        checks++;
        if (mode_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mode_valid got=%b want=0", mode_valid);
        end
        checks++;
        if (btn_db !== 5'b0) begin
            errors++;
            $display("FAIL reset_btn_db got=%b want=00000", btn_db);
        end
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_single_press();
        int p0;
        p0 = pulses;
        btnl = 1'b1;                    // held from edge 0
        step(5);                        // after edge 5
        checks++;
        if (btn_db !== 5'b00000) begin
            errors++;
            $display("FAIL left_db_early got=%b want=00000", btn_db);
        end
        step(1);                        // after edge 6
        checks++;
        if (btn_db !== 5'b00010) begin
            errors++;
            $display("FAIL left_db_edge6 got=%b want=00010", btn_db);
        end
        checks++;
        if (mode_valid !== 1'b0 || selector !== RESET) begin
            errors++;
            $display("FAIL left_sel_edge6 got=%0d/%b want=%0d/0", selector, mode_valid, RESET);
        end
        step(1);                        // after edge 7
        checks++;
        if (selector !== ADD || mode_valid !== 1'b1) begin
            errors++;
            $display("FAIL left_sel_edge7 got=%0d/%b want=%0d/1", selector, mode_valid, ADD);
        end
        step(1);                        // after edge 8
        checks++;
        if (mode_valid !== 1'b0) begin
            errors++;
            $display("FAIL left_valid_edge8 got=%b want=0", mode_valid);
        end
        btnl = 1'b0;
        step(10);
        checks++;
        if (selector !== ADD || btn_db !== 5'b0 || pulses - p0 !== 1) begin
            errors++;
            $display("FAIL left_release got=%0d/%b/%0d want=%0d/00000/1",
                     selector, btn_db, pulses - p0, ADD);
        end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pulses;
        btnr = 1'b1;                    // synced level high for exactly 3 edges
        step(3);
        btnr = 1'b0;
        step(12);
        checks++;
        if (btn_db !== 5'b0 || pulses != p0 || selector !== ADD) begin
            errors++;
            $display("FAIL glitch_3 got=%b/%0d/%0d want=00000/0/%0d",
                     btn_db, pulses - p0, selector, ADD);
        end
        // A 4-cycle pulse is just long enough to be accepted.
        p0 = pulses;
        btnr = 1'b1;
        step(4);
        btnr = 1'b0;
        step(12);
        checks++;
        if (selector !== SUB || pulses - p0 !== 1 || btn_db !== 5'b0) begin
            errors++;
            $display("FAIL pulse_4 got=%0d/%0d/%b want=%0d/1/00000",
                     selector, pulses - p0, btn_db, SUB);
        end
    endtask

    task automatic test_simultaneous();
        int p0;
        p0 = pulses;
        btnc = 1'b1;
        btnu = 1'b1;
        step(12);
        checks++;
        if (selector !== MUL || pulses - p0 !== 1 || btn_db !== 5'b11000) begin
            errors++;
            $display("FAIL c_u_same got=%0d/%0d/%b want=%0d/1/11000",
                     selector, pulses - p0, btn_db, MUL);
        end
        btnc = 1'b0;
        btnu = 1'b0;
        step(12);
        p0 = pulses;
        {btnd, btnl, btnr} = 3'b111;
        step(12);
        checks++;
        if (selector !== COUNT_ONES || pulses - p0 !== 1) begin
            errors++;
            $display("FAIL d_l_r_same got=%0d/%0d want=%0d/1",
                     selector, pulses - p0, COUNT_ONES);
        end
        {btnd, btnl, btnr} = 3'b000;
        step(12);
    endtask

    task automatic test_hold_repress();
        int p0;
        p0 = pulses;
        btnr = 1'b1;
        step(30);
        checks++;
        if (selector !== SUB || pulses - p0 !== 1) begin
            errors++;
            $display("FAIL hold_right got=%0d/%0d want=%0d/1", selector, pulses - p0, SUB);
        end
        btnr = 1'b0;
        step(20);
        checks++;
        if (selector !== SUB || pulses - p0 !== 1 || btn_db !== 5'b0) begin
            errors++;
            $display("FAIL release_hold got=%0d/%0d/%b want=%0d/1/00000",
                     selector, pulses - p0, btn_db, SUB);
        end
        btnr = 1'b1;
        step(7);
        checks++;
        if (mode_valid !== 1'b1 || selector !== SUB) begin
            errors++;
            $display("FAIL repress_right got=%b/%0d want=1/%0d", mode_valid, selector, SUB);
        end
        btnr = 1'b0;
        step(12);
    endtask

    task automatic test_reset_mid_debounce();
        btnd = 1'b1;                    // held from edge 0
        step(5);                        // counts 1,2,3 done at edges 3,4,5
        rst = 1'b1;
        #1;
        checks++;
        if (selector !== RESET || mode_valid !== 1'b0 || btn_db !== 5'b0) begin
            errors++;
            $display("FAIL mid_rst got=%0d/%b/%b want=%0d/0/00000",
                     selector, mode_valid, btn_db, RESET);
        end
        step(2);
        rst = 1'b0;                     // new edge 0
        step(5);
        checks++;
        if (btn_db !== 5'b0) begin
            errors++;
            $display("FAIL rst_discard got=%b want=00000", btn_db);
        end
        step(1);
        checks++;
        if (btn_db !== 5'b00100 || selector !== RESET) begin
            errors++;
            $display("FAIL rst_db_edge6 got=%b/%0d want=00100/%0d", btn_db, selector, RESET);
        end
        step(1);
        checks++;
        if (selector !== COUNT_ONES || mode_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_sel_edge7 got=%0d/%b want=%0d/1", selector, mode_valid, COUNT_ONES);
        end
        btnd = 1'b0;
        step(10);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_hold_repress();
        test_reset_mid_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
